// File: rtl/rram_ctrl_pkg.sv
// Purpose: shared state encoding, default phase lengths and latency helpers for the RRAM sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rram_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    RDVLP  = 3'd1,
    RPRE   = 3'd2,
    RSA    = 3'd3,
    RDONE  = 3'd4,
    WPULSE = 3'd5,
    WREC   = 3'd6
  } state_t;

  localparam int DEF_DVLP_CYC = 2;
  localparam int DEF_PRE_CYC  = 1;
  localparam int DEF_SA_CYC   = 1;
  localparam int DEF_WR_CYC   = 3;

  // Cycle (acceptance edge = cycle 0) in which rsp_valid is high.
  function automatic int rd_latency(input int dvlp, input int pre, input int sa);
    return dvlp + pre + sa + 1;
  endfunction

  function automatic int wr_latency(input int wr);
    return wr + 1;
  endfunction

endpackage

// File: rtl/rram_onehot_dec.sv
// Purpose: binary to one-hot decoder with an enable; all-zero output when disabled.
// Latency: combinational.
// Backpressure: none.
// Ports: bin (N-bit index), en (enable), onehot (2^N-bit select).
module rram_onehot_dec #(
  parameter int N = 3
) (
  input  logic [N-1:0]        bin,
  input  logic                en,
  output logic [(2**N)-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[bin] = 1'b1;
  end

endmodule

// File: rtl/rram_phase_timer.sv
// Purpose: loadable down-counter timing each sequencer phase; holds at zero.
// Latency: load takes effect at the next edge; zero flag is combinational from the count.
// Backpressure: none.
// Ports: clk, reset (sync, active-high), load, load_val, zero.
module rram_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rram_seq_ctrl.sv
// Purpose: RRAM array sequencer; read = develop/precharge/sense phases, write = pulse + recovery.
// Latency: read rsp in cycle DVLP+PRE+SA+1, write rsp in cycle WR+1 (acceptance edge = cycle 0).
// Backpressure: req_ready only in IDLE (and never while reset is high); one request in flight.
// Ports: req_* valid/ready request, rsp_valid/rsp_rdata completion, SA_OUT sense-amp input,
//        WDATA, P/N/Y decoder selects (+complements), P_EN_REF (+complement), phase strobes.
module rram_seq_ctrl
  import rram_ctrl_pkg::*;
#(
  parameter int B_SIZE   = 4,
  parameter int X_SIZE   = 3,
  parameter int Y_SIZE   = 5,
  parameter int CNT_W    = 4,
  parameter int DVLP_CYC = DEF_DVLP_CYC,
  parameter int PRE_CYC  = DEF_PRE_CYC,
  parameter int SA_CYC   = DEF_SA_CYC,
  parameter int WR_CYC   = DEF_WR_CYC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rw,
  input  logic [X_SIZE-1:0]       req_x,
  input  logic [Y_SIZE-1:0]       req_y,
  input  logic [B_SIZE-1:0]       req_wdata,
  output logic                    rsp_valid,
  output logic [B_SIZE-1:0]       rsp_rdata,
  input  logic [B_SIZE-1:0]       SA_OUT,
  output logic [B_SIZE-1:0]       WDATA,
  output logic [(2**X_SIZE)-1:0]  P_DECODER_OUT,
  output logic [(2**X_SIZE)-1:0]  NOT_P_DECODER_OUT,
  output logic [(2**X_SIZE)-1:0]  N_DECODER_OUT,
  output logic [(2**X_SIZE)-1:0]  NOT_N_DECODER_OUT,
  output logic [(2**Y_SIZE)-1:0]  Y_DECODER_OUT,
  output logic                    P_EN_REF,
  output logic                    NOT_P_EN_REF,
  output logic                    READ,
  output logic                    WRITE,
  output logic                    DVLP,
  output logic                    PRE,
  output logic                    EN_SA
);

  // Counters are loaded with LEN-1 so each timed phase lasts exactly LEN cycles.
  localparam logic [CNT_W-1:0] DVLP_LD = CNT_W'(DVLP_CYC - 1);
  localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] SA_LD   = CNT_W'(SA_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LD   = CNT_W'(WR_CYC - 1);

  state_t             state_q, state_d;
  logic [X_SIZE-1:0]  x_q;
  logic [Y_SIZE-1:0]  y_q;
  logic [B_SIZE-1:0]  wdata_q;
  logic               accept;
  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_zero;
  logic               p_en, n_en, y_en, wr_drive;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x_q     <= req_x;
        y_q     <= req_y;
        wdata_q <= req_wdata;
      end
      // Capture only on the last sense cycle, when the sense amps have settled.
      if (state_q == RSA && tmr_zero) rsp_rdata <= SA_OUT;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    p_en      = 1'b0;
    n_en      = 1'b0;
    y_en      = 1'b0;
    wr_drive  = 1'b0;
    P_EN_REF  = 1'b0;
    READ      = 1'b0;
    WRITE     = 1'b0;
    DVLP      = 1'b0;
    PRE       = 1'b0;
    EN_SA     = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tmr_load = 1'b1;
          if (req_rw) begin
            state_d = RDVLP;
            tmr_val = DVLP_LD;
          end else begin
            state_d = WPULSE;
            tmr_val = WR_LD;
          end
        end
      end
      RDVLP, RPRE: begin
        y_en     = 1'b1;
        p_en     = 1'b1;
        P_EN_REF = 1'b1;
        READ     = 1'b1;
        DVLP     = 1'b1;
        PRE      = (state_q == RPRE);
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (state_q == RDVLP) begin
            state_d = RPRE;
            tmr_val = PRE_LD;
          end else begin
            state_d = RSA;
            tmr_val = SA_LD;
          end
        end
      end
      RSA: begin
        READ  = 1'b1;
        PRE   = 1'b1;
        EN_SA = 1'b1;
        if (tmr_zero) state_d = RDONE;
      end
      WPULSE: begin
        y_en     = 1'b1;
        p_en     = 1'b1;
        n_en     = 1'b1;
        WRITE    = 1'b1;
        wr_drive = 1'b1;
        if (tmr_zero) state_d = WREC;
      end
      RDONE, WREC: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  rram_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  rram_onehot_dec #(.N(X_SIZE)) u_p_dec (.bin(x_q), .en(p_en), .onehot(P_DECODER_OUT));
  rram_onehot_dec #(.N(X_SIZE)) u_n_dec (.bin(x_q), .en(n_en), .onehot(N_DECODER_OUT));
  rram_onehot_dec #(.N(Y_SIZE)) u_y_dec (.bin(y_q), .en(y_en), .onehot(Y_DECODER_OUT));

  assign NOT_P_DECODER_OUT = ~P_DECODER_OUT;
  assign NOT_N_DECODER_OUT = ~N_DECODER_OUT;
  assign NOT_P_EN_REF      = ~P_EN_REF;
  assign WDATA             = wr_drive ? wdata_q : '0;

endmodule

// File: tb/tb_rram_seq_ctrl.sv
// Purpose: directed bench for rram_seq_ctrl (default instance plus a long-phase instance).
// Latency: n/a.
// Backpressure: n/a.
module tb_rram_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_rw;
  logic [2:0]  req_x;
  logic [4:0]  req_y;
  logic [3:0]  req_wdata, SA_OUT;
  logic        req_ready, rsp_valid;
  logic [3:0]  rsp_rdata, WDATA;
  logic [7:0]  P_DECODER_OUT, NOT_P_DECODER_OUT, N_DECODER_OUT, NOT_N_DECODER_OUT;
  logic [31:0] Y_DECODER_OUT;
  logic        P_EN_REF, NOT_P_EN_REF, READ, WRITE, DVLP, PRE, EN_SA;

  logic        req_valid_2, req_rw_2, req_ready_2, rsp_valid_2;
  logic [3:0]  rsp_rdata_2, WDATA_2;
  logic [7:0]  P_2, NP_2, N_2, NN_2;
  logic [31:0] Y_2;
  logic        P_EN_REF_2, NOT_P_EN_REF_2, READ_2, WRITE_2, DVLP_2, PRE_2, EN_SA_2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  rram_seq_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_x(req_x), .req_y(req_y), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .SA_OUT(SA_OUT), .WDATA(WDATA),
    .P_DECODER_OUT(P_DECODER_OUT), .NOT_P_DECODER_OUT(NOT_P_DECODER_OUT),
    .N_DECODER_OUT(N_DECODER_OUT), .NOT_N_DECODER_OUT(NOT_N_DECODER_OUT),
    .Y_DECODER_OUT(Y_DECODER_OUT), .P_EN_REF(P_EN_REF), .NOT_P_EN_REF(NOT_P_EN_REF),
    .READ(READ), .WRITE(WRITE), .DVLP(DVLP), .PRE(PRE), .EN_SA(EN_SA)
  );

  rram_seq_ctrl #(.DVLP_CYC(5), .PRE_CYC(3), .SA_CYC(2), .WR_CYC(1)) dut_sweep (
    .clk(clk), .reset(reset), .req_valid(req_valid_2), .req_ready(req_ready_2), .req_rw(req_rw_2),
    .req_x(req_x), .req_y(req_y), .req_wdata(req_wdata), .rsp_valid(rsp_valid_2),
    .rsp_rdata(rsp_rdata_2), .SA_OUT(SA_OUT), .WDATA(WDATA_2),
    .P_DECODER_OUT(P_2), .NOT_P_DECODER_OUT(NP_2),
    .N_DECODER_OUT(N_2), .NOT_N_DECODER_OUT(NN_2),
    .Y_DECODER_OUT(Y_2), .P_EN_REF(P_EN_REF_2), .NOT_P_EN_REF(NOT_P_EN_REF_2),
    .READ(READ_2), .WRITE(WRITE_2), .DVLP(DVLP_2), .PRE(PRE_2), .EN_SA(EN_SA_2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t, dv, sa, wr;
    logic exp_rdy, exp_rsp;

    // Reset held together with a read request: nothing may be accepted.
    reset = 1'b1; req_valid = 1'b1; req_rw = 1'b1; req_x = 3'd1; req_y = 5'd1;
    req_wdata = 4'h0; SA_OUT = 4'h0; req_valid_2 = 1'b0; req_rw_2 = 1'b0;
    step();
    check("rst_ready", req_ready, 1'b0);
    step();
    check("rst_read", READ, 1'b0);
    check("rst_p", P_DECODER_OUT, 8'h00);
    check("rst_notp", NOT_P_DECODER_OUT, 8'hFF);
    check("rst_notn", NOT_N_DECODER_OUT, 8'hFF);
    check("rst_y", Y_DECODER_OUT, 32'h0);
    check("rst_notref", NOT_P_EN_REF, 1'b1);
    check("rst_wdata", WDATA, 4'h0);
    check("rst_rdata", rsp_rdata, 4'h0);
    check("rst_rsp", rsp_valid, 1'b0);
    reset = 1'b0; req_valid = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 1'b1);
    step();
    check("no_accept_in_rst", READ | WRITE, 1'b0);

    // Read x=5 y=17, SA_OUT=A in the sense cycle.
    req_rw = 1'b1; req_x = 3'd5; req_y = 5'd17; req_valid = 1'b1;
    check("rd_ready", req_ready, 1'b1);
    step();                                     // cycle 1
    req_valid = 1'b0; req_x = 3'd2; req_y = 5'd3; // ignored after acceptance
    check("rd_c1_p", P_DECODER_OUT, 8'h20);
    check("rd_c1_notp", NOT_P_DECODER_OUT, 8'hDF);
    check("rd_c1_y", Y_DECODER_OUT, 32'h0002_0000);
    check("rd_c1_n", N_DECODER_OUT, 8'h00);
    check("rd_c1_strb", {P_EN_REF, READ, DVLP, PRE, EN_SA, WRITE}, 6'b111000);
    check("rd_c1_ready", req_ready, 1'b0);
    step();                                     // cycle 2
    check("rd_c2_strb", {DVLP, PRE, EN_SA}, 3'b100);
    check("rd_c2_p", P_DECODER_OUT, 8'h20);
    step();                                     // cycle 3
    check("rd_c3_strb", {DVLP, PRE, EN_SA, P_EN_REF}, 4'b1101);
    check("rd_c3_y", Y_DECODER_OUT, 32'h0002_0000);
    SA_OUT = 4'hA;
    step();                                     // cycle 4
    check("rd_c4_strb", {READ, DVLP, PRE, EN_SA, P_EN_REF}, 5'b10110);
    check("rd_c4_p", P_DECODER_OUT, 8'h00);
    check("rd_c4_y", Y_DECODER_OUT, 32'h0);
    check("rd_c4_rsp", rsp_valid, 1'b0);
    step();                                     // cycle 5
    check("rd_c5_rsp", rsp_valid, 1'b1);
    check("rd_c5_rdata", rsp_rdata, 4'hA);
    check("rd_c5_strb", {READ, PRE, EN_SA, DVLP}, 4'b0000);
    check("rd_c5_ready", req_ready, 1'b0);
    step();                                     // cycle 6, IDLE
    check("rd_c6_rsp", rsp_valid, 1'b0);
    check("rd_c6_ready", req_ready, 1'b1);

    // Write x=0 y=31 wdata=6.
    req_rw = 1'b0; req_x = 3'd0; req_y = 5'd31; req_wdata = 4'h6; req_valid = 1'b1;
    step();                                     // cycle 1
    req_valid = 1'b0; req_wdata = 4'h9;
    check("wr_c1_write", {WRITE, READ}, 2'b10);
    check("wr_c1_p", P_DECODER_OUT, 8'h01);
    check("wr_c1_n", N_DECODER_OUT, 8'h01);
    check("wr_c1_notn", NOT_N_DECODER_OUT, 8'hFE);
    check("wr_c1_y", Y_DECODER_OUT, 32'h8000_0000);
    check("wr_c1_wdata", WDATA, 4'h6);
    step();                                     // cycle 2
    check("wr_c2_write", WRITE, 1'b1);
    step();                                     // cycle 3
    check("wr_c3_write", WRITE, 1'b1);
    check("wr_c3_wdata", WDATA, 4'h6);
    check("wr_c3_rsp", rsp_valid, 1'b0);
    step();                                     // cycle 4
    check("wr_c4_rsp", rsp_valid, 1'b1);
    check("wr_c4_write", WRITE, 1'b0);
    check("wr_c4_wdata", WDATA, 4'h0);
    check("wr_c4_n", N_DECODER_OUT, 8'h00);
    check("wr_c4_rdata", rsp_rdata, 4'hA);
    step();
    check("wr_c5_rsp", rsp_valid, 1'b0);

    // Reset during precharge.
    req_rw = 1'b1; req_x = 3'd7; req_y = 5'd2; req_valid = 1'b1;
    step(); req_valid = 1'b0;                   // cycle 1
    step();                                     // cycle 2
    step();                                     // cycle 3 = RPRE
    check("rp_pre", PRE & DVLP, 1'b1);
    reset = 1'b1;
    step();
    check("rp_strb", {READ, WRITE, DVLP, PRE, EN_SA, P_EN_REF}, 6'b000000);
    check("rp_notp", NOT_P_DECODER_OUT, 8'hFF);
    check("rp_notn", NOT_N_DECODER_OUT, 8'hFF);
    check("rp_notref", NOT_P_EN_REF, 1'b1);
    check("rp_rsp", rsp_valid, 1'b0);
    check("rp_rdata", rsp_rdata, 4'h0);
    check("rp_ready_in_rst", req_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("rp_ready", req_ready, 1'b1);
    step();

    // req_valid held high, rw alternating read/write/read.
    // Expected: accepts in cycles 0, 6, 11; responses in cycles 5, 10, 16.
    req_rw = 1'b1; req_valid = 1'b1; SA_OUT = 4'h3;
    for (int c = 0; c <= 16; c++) begin
      exp_rdy = (c == 0) || (c == 6) || (c == 11);
      exp_rsp = (c == 5) || (c == 10) || (c == 16);
      check($sformatf("bk_ready_c%0d", c), req_ready, exp_rdy);
      check($sformatf("bk_rsp_c%0d", c), rsp_valid, exp_rsp);
      if (c == 16) req_valid = 1'b0;
      step();
      if (exp_rdy) req_rw = ~req_rw;
    end
    check("bk_rdata", rsp_rdata, 4'h3);

    // SA_OUT toggling across RSA and RDONE.
    req_rw = 1'b1; req_x = 3'd3; req_y = 5'd0; req_valid = 1'b1;
    step(); req_valid = 1'b0;                   // cycle 1
    step();                                     // cycle 2
    step(); SA_OUT = 4'h5;                      // cycle 3
    step(); SA_OUT = 4'h6;                      // cycle 4 = RSA
    check("tg_ensa", EN_SA, 1'b1);
    step(); SA_OUT = 4'h7;                      // cycle 5 = RDONE
    check("tg_rsp", rsp_valid, 1'b1);
    check("tg_rdata_c5", rsp_rdata, 4'h6);
    step(); SA_OUT = 4'h8;
    check("tg_rdata_c6", rsp_rdata, 4'h6);
    step();
    check("tg_rdata_c7", rsp_rdata, 4'h6);

    // Long-phase instance: read response in cycle 11, write in cycle 2.
    SA_OUT = 4'hC;
    req_rw_2 = 1'b1; req_valid_2 = 1'b1;
    step(); req_valid_2 = 1'b0;
    t = 1; dv = 0; sa = 0;
    while (!rsp_valid_2 && t < 40) begin
      dv += int'(DVLP_2);
      sa += int'(EN_SA_2);
      step();
      t++;
    end
    check("sw_rd_lat", t, 11);
    check("sw_dvlp_cycles", dv, 8);
    check("sw_ensa_cycles", sa, 2);
    check("sw_rdata", rsp_rdata_2, 4'hC);
    step();
    req_rw_2 = 1'b0; req_valid_2 = 1'b1;
    step(); req_valid_2 = 1'b0;
    t = 1; wr = 0;
    while (!rsp_valid_2 && t < 40) begin
      wr += int'(WRITE_2);
      step();
      t++;
    end
    check("sw_wr_lat", t, 2);
    check("sw_wr_cycles", wr, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
